out_channel_checker: RTL and testbench
======================================

Name: out_channel_checker

Overview:
- Consumer end of the program out channel: accepts words the running program emits, compares them in order against a preloaded expected table, and reports finished/success.
- Replaces the hard-coded end-of-program checks in test harnesses with a loadable, reusable checker.
- Sits beside the program executor; the executor is the producer on a valid/ready handshake.

Parameters:
MemoryElementWidth, 12, width of each channel word and of the expected entries
NExpect, 16, depth of the expected table (maximum checkable words)
IW, $clog2(NExpect), width of the table index

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state except the table
expWrite  input  1  write one expected entry (honoured in IDLE and DONE only)
expIndex  input  IW  expected-table write address
expData  input  MemoryElementWidth  expected-table write data
expCount  input  IW+1  number of words expected, sampled on start
start  input  1  begin a check run (honoured in IDLE and DONE only)
outValid  input  1  producer presents a word
outData  input  MemoryElementWidth  word from the program out channel
outReady  output  1  checker accepts a word this cycle
programDone  input  1  producer has executed its last instruction
finished  output  1  run complete
success  output  1  run passed (valid only while finished=1)
received  output  MemoryElementWidth  words accepted in this run
mismatchIndex  output  MemoryElementWidth  index of first mismatching word; all ones if none
overflow  output  1  more words received than expCount

Behaviour:
- Reset values: state=IDLE, outReady=0, finished=0, success=0, received=0, mismatchIndex=all ones, overflow=0. Reset is effective immediately and asynchronously, including mid-run. Expected table contents are not cleared.
- States: IDLE, RUN, DONE.
- IDLE: outReady=0. expWrite writes table[expIndex]=expData at the clock edge. start latches expCount into countReg, clears received, mismatchIndex, overflow, finished and success, then moves to RUN.
- RUN:
  - outReady=1 (registered decode of state). expWrite and start are ignored.
  - On outValid&&outReady with received<countReg: if outData != table[received] and mismatchIndex is all ones, mismatchIndex=received.
  - On outValid&&outReady with received>=countReg: overflow=1, sticky for the run. No table read occurs.
  - Every handshake increments received. received saturates at all ones and does not wrap.
  - programDone high moves to DONE on the next edge.
  - If programDone and a handshake occur in the same cycle, the word is counted and compared first, then the state moves to DONE.
- DONE:
  - outReady=0. outValid is ignored and no counting occurs.
  - finished=1 from the first DONE cycle.
  - success=1 iff mismatchIndex is all ones, overflow=0, and received==countReg.
  - Outputs hold until start (new run, straight to RUN with cleared results) or reset. expWrite is honoured in DONE to reload for the next run.
- expCount=0: a run passes only if no word is received before programDone.
- expCount>NExpect: clamp countReg to NExpect.
- Latency: a handshake updates received on the same edge. finished rises one cycle after programDone is sampled high in RUN.
- Table read: combinational, indexed by received[IW-1:0]. Table write: synchronous. Write and read of the same entry never coincide because writes happen only outside RUN.

Decomposition:
- Shared package out_channel_pkg: the state enum (IDLE/RUN/DONE) and the NoMismatch constant (all ones at MemoryElementWidth).
- One sub-module, expect_table: an NExpect x MemoryElementWidth register file with synchronous write port and asynchronous read port.
- The FSM, counters and compare stay in out_channel_checker.

Test Plan:
1. Load 11,22,33, expCount=3, start; push 11,22,33; programDone -> finished=1, success=1, received=3, mismatchIndex=0xFFF, overflow=0.
2. Same load; push 11,99,33; programDone -> success=0, mismatchIndex=1, received=3.
3. Same load; push 11,22 only; programDone -> success=0, received=2, mismatchIndex=0xFFF.
4. Same load; push 11,22,33,44 -> overflow=1 after the 4th word; after programDone, success=0, received=4.
5. Same load; push 11,22; third word 33 arrives with programDone in the same cycle -> word counted, success=1. Then outValid in DONE -> outReady=0, received stays 3.
6. Start the run, push 11, assert reset for 1 cycle -> outputs return to reset values asynchronously. Then start again without reloading; push 11,22,33; programDone -> success=1 (table preserved).

Source files
------------

// File: rtl/out_channel_pkg.sv
// Shared types and constants for the program out-channel checker.
// Holds the FSM state encoding and the "no mismatch seen" marker.
package out_channel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ElementWidth = 12;
    localparam logic [ElementWidth-1:0] NoMismatch = '1;

endpackage

// File: rtl/expect_table.sv
// Expected-word register file: synchronous write port, asynchronous read port.
// Contents are deliberately not reset so a table survives a checker reset.
module expect_table #(
    parameter int W  = 12,
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [IW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [N];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/out_channel_checker.sv
// Consumer end of the program out channel: compares accepted words in order
// against a preloaded expected table and reports finished/success.
module out_channel_checker
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = ElementWidth,
    parameter int NExpect            = 16,
    parameter int IW                 = $clog2(NExpect)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          expWrite,
    input  logic [IW-1:0]                 expIndex,
    input  logic [MemoryElementWidth-1:0] expData,
    input  logic [IW:0]                   expCount,
    input  logic                          start,
    input  logic                          outValid,
    input  logic [MemoryElementWidth-1:0] outData,
    output logic                          outReady,
    input  logic                          programDone,
    output logic                          finished,
    output logic                          success,
    output logic [MemoryElementWidth-1:0] received,
    output logic [MemoryElementWidth-1:0] mismatchIndex,
    output logic                          overflow
);

    // Replicate the package marker bit so the constant tracks any element width.
    localparam logic [MemoryElementWidth-1:0] NoMatch = {MemoryElementWidth{NoMismatch[0]}};
    localparam logic [IW:0] CountMax = (IW+1)'(NExpect);

    state_t state, state_next;

    logic                          idle_or_done;
    logic                          handshake;
    logic                          in_range;
    logic [IW:0]                   countReg;
    logic [IW:0]                   count_clamped;
    logic [MemoryElementWidth-1:0] count_ext;
    logic [MemoryElementWidth-1:0] exp_word;

    assign idle_or_done  = (state == IDLE) || (state == DONE);
    assign handshake     = outValid && outReady;
    assign count_clamped = (expCount > CountMax) ? CountMax : expCount;
    assign count_ext     = MemoryElementWidth'(countReg);
    assign in_range      = (received < count_ext);

    expect_table #(
        .W  (MemoryElementWidth),
        .N  (NExpect),
        .IW (IW)
    ) u_table (
        .clock (clock),
        .we    (expWrite && idle_or_done),
        .waddr (expIndex),
        .wdata (expData),
        .raddr (received[IW-1:0]),
        .rdata (exp_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)       state_next = RUN;
            RUN:     if (programDone) state_next = DONE;
            DONE:    if (start)       state_next = RUN;
            default:                  state_next = IDLE;
        endcase
    end

    // outReady is a registered decode of the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outReady <= 1'b0;
        end else begin
            outReady <= (state_next == RUN);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            countReg      <= '0;
            received      <= '0;
            mismatchIndex <= NoMatch;
            overflow      <= 1'b0;
        end else if (idle_or_done && start) begin
            countReg      <= count_clamped;
            received      <= '0;
            mismatchIndex <= NoMatch;
            overflow      <= 1'b0;
        end else if (handshake) begin
            // Words past the expected count never touch the table.
            if (in_range) begin
                if ((outData != exp_word) && (mismatchIndex == NoMatch)) begin
                    mismatchIndex <= received;
                end
            end else begin
                overflow <= 1'b1;
            end
            if (received != NoMatch) begin
                received <= received + 1'b1;
            end
        end
    end

    assign finished = (state == DONE);
    assign success  = finished && (mismatchIndex == NoMatch) && !overflow
                      && (received == count_ext);

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed bench for out_channel_checker: each scenario task drives vectors
// and compares outputs against hand-computed values.
module tb_out_channel_checker;

    localparam int W  = 12;
    localparam int N  = 16;
    localparam int IW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          expWrite;
    logic [IW-1:0] expIndex;
    logic [W-1:0]  expData;
    logic [IW:0]   expCount;
    logic          start;
    logic          outValid;
    logic [W-1:0]  outData;
    logic          outReady;
    logic          programDone;
    logic          finished;
    logic          success;
    logic [W-1:0]  received;
    logic [W-1:0]  mismatchIndex;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    out_channel_checker #(
        .MemoryElementWidth (W),
        .NExpect            (N),
        .IW                 (IW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .expWrite      (expWrite),
        .expIndex      (expIndex),
        .expData       (expData),
        .expCount      (expCount),
        .start         (start),
        .outValid      (outValid),
        .outData       (outData),
        .outReady      (outReady),
        .programDone   (programDone),
        .finished      (finished),
        .success       (success),
        .received      (received),
        .mismatchIndex (mismatchIndex),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int idx, input logic [W-1:0] val);
        expWrite = 1'b1;
        expIndex = IW'(idx);
        expData  = val;
        tick();
        expWrite = 1'b0;
    endtask

    task automatic start_run(input int n);
        expCount = (IW+1)'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] w);
        outValid = 1'b1;
        outData  = w;
        tick();
        outValid = 1'b0;
    endtask

    task automatic end_program();
        programDone = 1'b1;
        tick();
        programDone = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        expWrite = 0; expIndex = 0; expData = 0; expCount = 0;
        start = 0; outValid = 0; outData = 0; programDone = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
        total++; if (outReady !== 1'b0) begin bad++; $display("FAIL reset_outReady got=%0b want=0", outReady); end
        total++; if (finished !== 1'b0) begin bad++; $display("FAIL reset_finished got=%0b want=0", finished); end
        total++; if (success !== 1'b0) begin bad++; $display("FAIL reset_success got=%0b want=0", success); end
        total++; if (received !== 12'd0) begin bad++; $display("FAIL reset_received got=%0d want=0", received); end
        total++; if (mismatchIndex !== 12'hFFF) begin bad++; $display("FAIL reset_mismatch got=%h want=fff", mismatchIndex); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
    endtask

    task automatic test_pass();
        load(0, 12'd11); load(1, 12'd22); load(2, 12'd33);
        start_run(3);
        total++; if (outReady !== 1'b1) begin bad++; $display("FAIL pass_ready got=%0b want=1", outReady); end
        // write during RUN must be ignored
        load(1, 12'h777);
        push(12'd11); push(12'd22); push(12'd33);
        end_program();
        total++; if (finished !== 1'b1) begin bad++; $display("FAIL pass_finished got=%0b want=1", finished); end
        total++; if (success !== 1'b1) begin bad++; $display("FAIL pass_success got=%0b want=1", success); end
        total++; if (received !== 12'd3) begin bad++; $display("FAIL pass_received got=%0d want=3", received); end
        total++; if (mismatchIndex !== 12'hFFF) begin bad++; $display("FAIL pass_mismatch got=%h want=fff", mismatchIndex); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pass_overflow got=%0b want=0", overflow); end
        total++; if (outReady !== 1'b0) begin bad++; $display("FAIL pass_done_ready got=%0b want=0", outReady); end
    endtask

    task automatic test_mismatch();
        start_run(3);
        total++; if (finished !== 1'b0) begin bad++; $display("FAIL mm_restart_finished got=%0b want=0", finished); end
        push(12'd11); push(12'd99); push(12'd33);
        end_program();
        total++; if (success !== 1'b0) begin bad++; $display("FAIL mm_success got=%0b want=0", success); end
        total++; if (mismatchIndex !== 12'd1) begin bad++; $display("FAIL mm_index got=%h want=001", mismatchIndex); end
        total++; if (received !== 12'd3) begin bad++; $display("FAIL mm_received got=%0d want=3", received); end
    endtask

    task automatic test_short();
        start_run(3);
        push(12'd11); push(12'd22);
        end_program();
        total++; if (success !== 1'b0) begin bad++; $display("FAIL short_success got=%0b want=0", success); end
        total++; if (received !== 12'd2) begin bad++; $display("FAIL short_received got=%0d want=2", received); end
        total++; if (mismatchIndex !== 12'hFFF) begin bad++; $display("FAIL short_mismatch got=%h want=fff", mismatchIndex); end
    endtask

    task automatic test_overflow();
        start_run(3);
        push(12'd11); push(12'd22); push(12'd33);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b want=0", overflow); end
        push(12'd44);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", overflow); end
        end_program();
        total++; if (success !== 1'b0) begin bad++; $display("FAIL ovf_success got=%0b want=0", success); end
        total++; if (received !== 12'd4) begin bad++; $display("FAIL ovf_received got=%0d want=4", received); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", overflow); end
    endtask

    task automatic test_back_to_back();
        start_run(3);
        push(12'd11); push(12'd22);
        outValid = 1'b1; outData = 12'd33; programDone = 1'b1;
        tick();
        outValid = 1'b0; programDone = 1'b0;
        total++; if (finished !== 1'b1) begin bad++; $display("FAIL b2b_finished got=%0b want=1", finished); end
        total++; if (received !== 12'd3) begin bad++; $display("FAIL b2b_received got=%0d want=3", received); end
        total++; if (success !== 1'b1) begin bad++; $display("FAIL b2b_success got=%0b want=1", success); end
        outValid = 1'b1; outData = 12'd55;
        total++; if (outReady !== 1'b0) begin bad++; $display("FAIL b2b_done_ready got=%0b want=0", outReady); end
        tick(); tick();
        outValid = 1'b0;
        total++; if (received !== 12'd3) begin bad++; $display("FAIL b2b_done_hold got=%0d want=3", received); end
        total++; if (success !== 1'b1) begin bad++; $display("FAIL b2b_done_success got=%0b want=1", success); end
    endtask

    task automatic test_reset_midrun();
        start_run(3);
        push(12'd11);
        total++; if (received !== 12'd1) begin bad++; $display("FAIL mid_pre_received got=%0d want=1", received); end
        reset = 1'b1;
        #2;
        total++; if (received !== 12'd0) begin bad++; $display("FAIL mid_async_received got=%0d want=0", received); end
        total++; if (outReady !== 1'b0) begin bad++; $display("FAIL mid_async_ready got=%0b want=0", outReady); end
        total++; if (mismatchIndex !== 12'hFFF) begin bad++; $display("FAIL mid_async_mismatch got=%h want=fff", mismatchIndex); end
        tick();
        reset = 1'b0;
        tick();
        start_run(3);
        push(12'd11); push(12'd22); push(12'd33);
        end_program();
        total++; if (success !== 1'b1) begin bad++; $display("FAIL mid_table_kept got=%0b want=1", success); end
        total++; if (received !== 12'd3) begin bad++; $display("FAIL mid_received got=%0d want=3", received); end
    endtask

    task automatic test_count_bounds();
        // zero expected words: no word may arrive
        start_run(0);
        end_program();
        total++; if (success !== 1'b1) begin bad++; $display("FAIL zero_empty_success got=%0b want=1", success); end
        start_run(0);
        push(12'd11);
        end_program();
        total++; if (success !== 1'b0) begin bad++; $display("FAIL zero_word_success got=%0b want=0", success); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL zero_word_overflow got=%0b want=1", overflow); end
        // expCount above the table depth clamps to the depth
        for (int i = 0; i < N; i++) load(i, W'(i * 5 + 1));
        start_run(20);
        for (int i = 0; i < N; i++) push(W'(i * 5 + 1));
        end_program();
        total++; if (success !== 1'b1) begin bad++; $display("FAIL clamp_success got=%0b want=1", success); end
        total++; if (received !== 12'd16) begin bad++; $display("FAIL clamp_received got=%0d want=16", received); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_short();
        test_overflow();
        test_back_to_back();
        test_reset_midrun();
        test_count_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
